// File: rtl/block_lock_fsm.sv
// block_lock_fsm
//   10GBASE-R receive block-lock state machine. Watches sync headers from
//   block_sync, asks block_sync to slip one bit position whenever alignment
//   looks wrong, and declares lock once a full window of headers is clean.
//
// Ports
//   i_clk                receive clock
//   i_reset_n            asynchronous active-low reset
//   i_rx_sync_hdr        sync header from block_sync
//   i_rx_sync_hdr_valid  header qualifier, one cycle per 66b block
//   o_slip               one-cycle slip request to block_sync
//   o_block_lock         alignment acquired
//   o_sh_invalid_cnt     invalid headers seen in the current window (debug)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// TEST_SH    | sampling headers, counting the window, deciding lock/slip
// SLIP       | o_slip high for this one cycle, counters already cleared
// SLIP_WAIT  | headers ignored while block_sync realigns
module block_lock_fsm #(
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_rx_sync_hdr,
  input  logic                 i_rx_sync_hdr_valid,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic [4:0]           o_sh_invalid_cnt
);

  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [6:0]        CNT_MAX   = 7'(SH_CNT_MAX);
  localparam logic [4:0]        INV_MAX   = 5'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    TEST_SH   = 2'd0,
    SLIP      = 2'd1,
    SLIP_WAIT_ST = 2'd2
  } state_t;

  state_t            state;
  logic [6:0]        sh_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic       hdr_bad;
  logic [6:0] cnt_next;
  logic [4:0] inv_next;

  // Only 01 and 10 are legal headers: both bits equal means invalid.
  assign hdr_bad  = ~^i_rx_sync_hdr;
  assign cnt_next = sh_cnt + 7'd1;
  // Invalid count saturates so a long bad burst cannot wrap back to zero.
  assign inv_next = (hdr_bad && (o_sh_invalid_cnt != INV_MAX)) ?
                    o_sh_invalid_cnt + 5'd1 : o_sh_invalid_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= TEST_SH;
      sh_cnt           <= '0;
      wait_cnt         <= '0;
      o_slip           <= 1'b0;
      o_block_lock     <= 1'b0;
      o_sh_invalid_cnt <= '0;
    end else begin
      case (state)
        TEST_SH: begin
          o_slip <= 1'b0;
          if (i_rx_sync_hdr_valid) begin
            if ((!o_block_lock && hdr_bad) ||
                (o_block_lock && (inv_next == INV_MAX))) begin
              // Loss of lock takes priority over a window ending on this header.
              state            <= SLIP;
              o_slip           <= 1'b1;
              o_block_lock     <= 1'b0;
              sh_cnt           <= '0;
              o_sh_invalid_cnt <= '0;
            end else if (cnt_next == CNT_MAX) begin
              if (inv_next == '0) begin
                o_block_lock <= 1'b1;
              end
              sh_cnt           <= '0;
              o_sh_invalid_cnt <= '0;
            end else begin
              sh_cnt           <= cnt_next;
              o_sh_invalid_cnt <= inv_next;
            end
          end
        end

        SLIP: begin
          // A strobe landing here belongs to the old alignment and is dropped.
          o_slip   <= 1'b0;
          wait_cnt <= WAIT_LOAD;
          state    <= SLIP_WAIT_ST;
        end

        SLIP_WAIT_ST: begin
          o_slip <= 1'b0;
          if (wait_cnt == '0) begin
            state <= TEST_SH;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        default: begin
          state            <= TEST_SH;
          sh_cnt           <= '0;
          wait_cnt         <= '0;
          o_slip           <= 1'b0;
          o_block_lock     <= 1'b0;
          o_sh_invalid_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_lock_fsm.sv
module tb_block_lock_fsm;

  localparam int SH_CNT_MAX     = 64;
  localparam int SH_INVALID_MAX = 16;
  localparam int SLIP_WAIT      = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] hdr   = 2'b01;
  logic       vld   = 1'b0;
  logic       slip;
  logic       lock;
  logic [4:0] inv_cnt;

  int tests  = 0;
  int failed = 0;

  block_lock_fsm #(
    .HDR_WIDTH     (2),
    .SH_CNT_MAX    (SH_CNT_MAX),
    .SH_INVALID_MAX(SH_INVALID_MAX),
    .SLIP_WAIT     (SLIP_WAIT)
  ) dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_rx_sync_hdr      (hdr),
    .i_rx_sync_hdr_valid(vld),
    .o_slip             (slip),
    .o_block_lock       (lock),
    .o_sh_invalid_cnt   (inv_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a window is a count of accepted headers; a slip
  // makes the receiver blind for the slip cycle plus SLIP_WAIT cycles.
  int m_hdrs  = 0;
  int m_bad   = 0;
  int m_blind = 0;
  int m_lock  = 0;
  int m_slip  = 0;
  int m_isbad = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hdrs = 0; m_bad = 0; m_blind = 0; m_lock = 0; m_slip = 0;
    end else begin
      m_slip = 0;
      if (m_blind > 0) begin
        m_blind--;
      end else if (vld) begin
        m_isbad = (hdr == 2'b00 || hdr == 2'b11) ? 1 : 0;
        m_hdrs++;
        if (m_isbad == 1 && m_bad < SH_INVALID_MAX) m_bad++;
        if (m_isbad == 1 && (m_lock == 0 || m_bad >= SH_INVALID_MAX)) begin
          m_slip = 1; m_lock = 0; m_hdrs = 0; m_bad = 0;
          m_blind = SLIP_WAIT + 1;
        end else if (m_hdrs == SH_CNT_MAX) begin
          if (m_bad == 0) m_lock = 1;
          m_hdrs = 0; m_bad = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_lock", int'(lock), m_lock);
      chk("model_slip", int'(slip), m_slip);
      chk("model_inv_cnt", int'(inv_cnt), m_bad);
    end
  end

  // One strobed header; returns just after the sampling edge.
  task automatic send(input logic [1:0] h);
    @(negedge clk);
    hdr = h; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n valid headers with a gap cycle between them.
  task automatic send_valid_gapped(input int n);
    for (int i = 0; i < n; i++) begin
      send((i % 2 == 0) ? 2'b01 : 2'b10);
      if (i != n - 1) idle(1);
    end
  endtask

  task automatic send_valid(input int n);
    for (int i = 0; i < n; i++) send((i % 2 == 0) ? 2'b10 : 2'b01);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    chk("reset_lock", int'(lock), 0);
    chk("reset_slip", int'(slip), 0);
    chk("reset_inv", int'(inv_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean acquisition, one header every other cycle.
    send_valid_gapped(63);
    chk("acq_lock_63", int'(lock), 0);
    idle(1);
    send(2'b01);
    chk("acq_lock_64", int'(lock), 1);

    // Unlocked slip on header #10, blind period, then reacquire.
    do_reset();
    send_valid(9);
    send(2'b00);
    chk("slip_pulse", int'(slip), 1);
    chk("slip_lock", int'(lock), 0);
    for (int i = 0; i < 8; i++) send(2'b00);
    chk("blind_inv", int'(inv_cnt), 0);
    chk("blind_slip", int'(slip), 0);
    idle(1);
    send_valid(63);
    chk("reacq_lock_63", int'(lock), 0);
    send(2'b10);
    chk("reacq_lock_64", int'(lock), 1);

    // Two locked windows with 15 invalid headers each.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 63; i++) send((i % 4 == 0 && i < 60) ? 2'b11 : 2'b01);
      chk("w15_inv_63", int'(inv_cnt), 15);
      send(2'b10);
      chk("w15_inv_end", int'(inv_cnt), 0);
      chk("w15_lock", int'(lock), 1);
    end

    // 16 consecutive invalid headers drop lock.
    for (int i = 0; i < 15; i++) send(2'b11);
    chk("l16_lock_15", int'(lock), 1);
    chk("l16_inv_15", int'(inv_cnt), 15);
    send(2'b11);
    chk("l16_lock", int'(lock), 0);
    chk("l16_slip", int'(slip), 1);
    idle(10);
    send_valid(64);
    chk("l16_relock", int'(lock), 1);

    // 16th invalid header is also the 64th header of the window.
    send_valid(48);
    for (int i = 0; i < 16; i++) send(2'b00);
    chk("edge_lock", int'(lock), 0);
    chk("edge_slip", int'(slip), 1);

    // No strobes: nothing moves, unlocked then locked.
    hdr = 2'b00;
    idle(200);
    chk("idle_unlocked", int'(lock), 0);
    send_valid(64);
    chk("idle_relock", int'(lock), 1);
    hdr = 2'b00;
    idle(200);
    chk("idle_locked", int'(lock), 1);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 17; i++) send((i == 2 || i == 7 || i == 11) ? 2'b11 : 2'b01);
    chk("mid_inv", int'(inv_cnt), 3);
    chk("mid_lock", int'(lock), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lock", int'(lock), 0);
    chk("async_slip", int'(slip), 0);
    chk("async_inv", int'(inv_cnt), 0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    send_valid(63);
    chk("post_rst_63", int'(lock), 0);
    send(2'b01);
    chk("post_rst_64", int'(lock), 1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/block_lock_fsm.md
Name: block_lock_fsm

Overview:
- Block-lock state machine for the 10GBASE-R PCS receive path, per IEEE 802.3 Clause 49 lock_state.
- Sits directly downstream of block_sync and consumes its 2-bit sync header and header-valid strobe.
- Drives block_sync's i_slip input to walk the 66b alignment until headers are consistently valid.
- Exports block_lock to the descrambler/decoder.

Parameters:
- HDR_WIDTH, 2: sync header width.
- SH_CNT_MAX, 64: headers per test window.
- SH_INVALID_MAX, 16: invalid headers in a window that force loss of lock.
- SLIP_WAIT, 8: clock cycles headers are ignored after a slip pulse, while block_sync realigns; minimum 1.

Ports:
- i_clk  input  1  receive clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_rx_sync_hdr  input  HDR_WIDTH  sync header from block_sync.
- i_rx_sync_hdr_valid  input  1  header qualifier; high one cycle per 66b block.
- o_slip  output  1  one-cycle slip request to block_sync i_slip.
- o_block_lock  output  1  alignment acquired.
- o_sh_invalid_cnt  output  5  current window invalid count (debug).

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset is asynchronous, active-low on i_reset_n.
  - Reset values: o_slip=0, o_block_lock=0, o_sh_invalid_cnt=0, sh_cnt=0, wait_cnt=0, state=TEST_SH.
  - Asserting reset mid-operation clears all of these immediately, without waiting for a clock edge.
- Header classification: 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are invalid.
- Header sampling: a header is sampled only on a rising edge where i_rx_sync_hdr_valid=1. i_rx_sync_hdr is a don't-care otherwise.
- Counters:
  - sh_cnt is 7 bits and counts sampled headers in the window.
  - sh_invalid_cnt is 5 bits and counts invalid headers in the window.
  - All outputs are registered.
- State TEST_SH: each sampled header increments sh_cnt; an invalid header also increments sh_invalid_cnt. Transitions are evaluated on the updated counts, in this priority:
  1. If o_block_lock=0 and the header is invalid: go to SLIP.
  2. If o_block_lock=1 and the new sh_invalid_cnt equals SH_INVALID_MAX: go to SLIP, and o_block_lock falls on the same edge.
  3. If the new sh_cnt equals SH_CNT_MAX and sh_invalid_cnt=0: set o_block_lock=1, clear the counters, stay in TEST_SH.
  4. If the new sh_cnt equals SH_CNT_MAX and 0 < sh_invalid_cnt < SH_INVALID_MAX (locked only): clear the counters, keep lock, stay in TEST_SH.
- State SLIP:
  - o_slip=1 for exactly one cycle, the cycle immediately after the offending header was sampled.
  - sh_cnt and sh_invalid_cnt are cleared.
  - o_block_lock=0.
  - Next state is SLIP_WAIT with wait_cnt loaded to SLIP_WAIT-1.
- State SLIP_WAIT:
  - i_rx_sync_hdr_valid is ignored.
  - wait_cnt decrements each cycle; at 0, return to TEST_SH.
  - o_slip=0 throughout.
- Timing:
  - Lock latency: o_block_lock rises on the edge that samples the 64th consecutive valid header, i.e. it is visible the cycle after that header's valid strobe.
  - Slip spacing: the minimum gap between two o_slip pulses is SLIP_WAIT+1 cycles plus one sampled header.
- Boundary conditions:
  - When the 16th invalid header is also the 64th header of the window, rule 2 (loss of lock) wins.
  - A header strobe arriving on the SLIP cycle is dropped.
  - sh_cnt never exceeds SH_CNT_MAX.
  - sh_invalid_cnt saturates at SH_INVALID_MAX.
- o_sh_invalid_cnt mirrors sh_invalid_cnt.

Test Plan:
- Reset, then 64 strobed headers alternating 01/10 every other cycle -> o_block_lock=1 one cycle after the 64th strobe; o_slip never asserted.
- Unlocked; valid headers with 2'b00 as header #10 -> o_slip pulses exactly one cycle after #10; the strobe inside the following 8 cycles is ignored; 64 further valid headers then lock.
- Locked; 15 headers of 2'b11 spread over a 64-header window -> lock held, o_sh_invalid_cnt reaches 15 then clears to 0 at window end; a repeat window gives the same result.
- Locked; 16 invalid headers within a window -> o_block_lock falls and o_slip pulses on the edge after the 16th invalid; the 16th invalid as the 64th header gives the same result.
- i_rx_sync_hdr_valid=0 with i_rx_sync_hdr=2'b00 held for 200 cycles, locked or unlocked -> no counter change, no slip.
- Locked mid-window; drop i_reset_n between clock edges -> o_block_lock, o_slip and o_sh_invalid_cnt go to 0 without an edge; after release, 64 valid headers are needed to relock.
